motor_bcd_display: RTL and testbench
====================================

Name: motor_bcd_display

Overview:
- Downstream stage of the DC-motor model/controller.
- Takes one unsigned binary motor quantity per request (speed Wr, armature current Ia or field current If, already integer-scaled) and converts it to decimal with a sequential shift-and-add-3 (double-dabble) engine.
- Drives DIGITS seven-segment displays, registered, with a start/busy/done handshake.
- One conversion at a time; display holds the last completed value.

Parameters:
- WIDTH, 14, bit width of Value. Must satisfy 2^WIDTH > 10^DIGITS-1.
- DIGITS, 4, number of decimal digits/displays.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Load  input  1  conversion request; sampled only in IDLE.
- Value  input  WIDTH  unsigned binary value; captured on the accepted Load edge.
- Busy  output  1  high while state != IDLE.
- Done  output  1  one-cycle pulse; Seg updates on the same edge.
- Overflow  output  1  registered with Seg; Value exceeded 10^DIGITS-1 and was saturated.
- Seg  output  7*DIGITS  segment bus. Digit i (i=0 least significant) occupies bits 7*i..7*i+6, lowest index = segment a, through g. Active-low: 0 = lit.

Behaviour:
- Reset (Reset_n low, async):
  - State=IDLE; Busy=0, Done=0, Overflow=0.
  - Every Seg bit=1 (all blank).
  - Internal shift/BCD registers cleared.
  - Reset mid-conversion aborts it; Seg does not show partial results.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Load=1 at an edge captures sat=min(Value, 10^DIGITS-1) into the binary shift register.
  - Clears the BCD register (4*DIGITS bits) and the count.
  - Latches ovf=(Value > 10^DIGITS-1).
  - Moves to SHIFT.
- SHIFT:
  - Each cycle: every BCD nibble >=5 gets +3 (all nibbles in parallel, combinational).
  - Then {BCD,bin} shifts left one bit.
  - Count increments; after exactly WIDTH shifts, goes to DONE.
- DONE (one cycle):
  - Seg <= encoding of the final BCD nibbles; Overflow <= ovf.
  - Done=1 for this cycle only; next state IDLE.
- Latency: Load accepted at edge 0, Done high and Seg updated after edge WIDTH+1. Throughput is one conversion per WIDTH+2 cycles.
- Load while Busy=1 (SHIFT or DONE) is ignored and not queued.
- Value changes after the capture edge do not affect the result.
- Digit encoding, a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Any nibble >9 (unreachable) = 1111111.
- Value=0 displays all digits "0".
- Value=10^DIGITS-1 is not overflow.
- Seg and Overflow are held between conversions.

Optional Feature:
- Macro MOTOR_BCD_BLANK_LEADING_ZERO_EN.
- Defined: in the DONE update, each digit above digit 0 is blanked (1111111) if it and all more-significant digits are zero. Digit 0 is always shown. Example: 125 shows " 125", 0 shows "   0".
- Undefined: all digits are always shown, zero-padded ("0125").
- Latency and handshake are identical in both cases.

Decomposition:
- Package motor_bcd_pkg:
  - state enum (IDLE/SHIFT/DONE);
  - SEG_BLANK constant (7'b1111111);
  - ten digit pattern constants;
  - function max_decimal(DIGITS) returning 10^DIGITS-1.
- One sub-module: seg7_digit_enc, combinational, 4-bit BCD in, 7-bit active-low a..g out. Instantiated DIGITS times.

Test Plan:
- Value=125, Load one cycle: Busy high, Done high exactly 15 cycles after the Load edge. Seg digits 3..0 = 0000001, 1001111, 0010010, 0100100; Overflow=0. With the optional feature, digit 3 = 1111111.
- Value=12000 (>9999): all four digits = 0000100; Overflow=1. Then Value=9999: digits = 9, Overflow=0.
- Value=0, then Value=16383 (max 14-bit): first gives all 0000001; second saturates to 9999 with Overflow=1.
- Load=1 held continuously with changing Value: only values sampled in IDLE are converted. Done pulses every 16 cycles; Load during SHIFT/DONE has no effect.
- Assert Reset_n=0 at cycle 7 of a conversion of 125, release, no Load: Seg all 1, Busy=0, Done never pulses. A following Load of 42 gives digits 0,0,4,2.
- Load 125, wait for Done, idle 20 cycles: Seg and Overflow remain unchanged and Done stays 0.

Source files
------------

// File: rtl/motor_bcd_display_pkg.sv
// Shared types and constants for the motor BCD display: FSM states,
// active-low seven-segment patterns (bit 0 = segment a) and decimal range.
package motor_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Patterns are packed g..a so that bit 0 lands on segment a.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  function automatic int unsigned max_decimal(input int unsigned digits);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/motor_bcd_display_if.sv
// Request/result bundle between the motor controller and the BCD display.
interface motor_bcd_display_if #(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 4
);
  logic                  Load;
  logic [WIDTH-1:0]      Value;
  logic                  Busy;
  logic                  Done;
  logic                  Overflow;
  logic [7*DIGITS-1:0]   Seg;

  modport master (output Load, Value, input Busy, Done, Overflow, Seg);
  modport slave  (input Load, Value, output Busy, Done, Overflow, Seg);
endinterface

// File: rtl/motor_bcd_display_seg7_digit_enc.sv
// Combinational BCD nibble to active-low seven-segment encoder (bit 0 = a).
module seg7_digit_enc
  import motor_bcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/motor_bcd_display.sv
// Sequential double-dabble binary-to-decimal converter driving DIGITS
// seven-segment displays. Define MOTOR_BCD_BLANK_LEADING_ZERO_EN to blank leading zeros.
module motor_bcd_display
  import motor_bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                Clock,
  input  logic                Reset_n,
  motor_bcd_display_if.slave  bus
);

  localparam int unsigned     BW      = 4 * DIGITS;
  localparam int unsigned     CW      = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_SAT = WIDTH'(max_decimal(DIGITS));

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    bin;
  logic [BW-1:0]       bcd, bcd_adj;
  logic [CW-1:0]       count;
  logic                ovf, ovf_q, done_q;
  logic [7*DIGITS-1:0] seg_q, seg_nxt;
  logic [6:0]          enc [DIGITS];
  logic                last_shift;

  assign last_shift = (count == CW'(WIDTH - 1));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Load) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_digit_enc u_enc (
      .bcd (bcd[4*g +: 4]),
      .seg (enc[g])
    );
  end

`ifdef MOTOR_BCD_BLANK_LEADING_ZERO_EN
  logic lead;

  // Walk from the most significant digit; blanking stops at the first non-zero.
  always_comb begin
    seg_nxt = '1;
    lead    = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (lead && (k != DIGITS - 1) && (bcd[4*(DIGITS-1-k) +: 4] == 4'd0)) begin
        seg_nxt[7*(DIGITS-1-k) +: 7] = SEG_BLANK;
      end else begin
        lead = 1'b0;
        seg_nxt[7*(DIGITS-1-k) +: 7] = enc[DIGITS-1-k];
      end
    end
  end
`else
  always_comb begin
    seg_nxt = '1;
    for (int unsigned i = 0; i < DIGITS; i++) seg_nxt[7*i +: 7] = enc[i];
  end
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      bin    <= '0;
      bcd    <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      seg_q  <= '1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.Load) begin
          bin   <= (bus.Value > MAX_SAT) ? MAX_SAT : bus.Value;
          bcd   <= '0;
          count <= '0;
          ovf   <= (bus.Value > MAX_SAT);
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          count      <= count + CW'(1);
        end
        DONE: begin
          seg_q  <= seg_nxt;
          ovf_q  <= ovf;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy     = (state != IDLE);
  assign bus.Done     = done_q;
  assign bus.Overflow = ovf_q;
  assign bus.Seg      = seg_q;

endmodule

// File: tb/tb_motor_bcd_display.sv
// Self-checking bench for motor_bcd_display: directed table, random values
// against a decimal-arithmetic model, continuous load, mid-conversion reset.
module tb_motor_bcd_display;

  localparam int unsigned WIDTH  = 14;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned LAT    = WIDTH + 1;
`ifdef MOTOR_BCD_BLANK_LEADING_ZERO_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  motor_bcd_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  motor_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Patterns written a..g, left to right
  logic [6:0] spec_pat [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100};

  typedef struct {
    logic [13:0] value;
    int          d3, d2, d1, d0;
    logic        ovf;
  } vec_t;

  typedef struct {
    int          done_edge;
    int unsigned val;
  } pend_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    logic [6:0] s, r;
    s = spec_pat[d];
    for (int b = 0; b < 7; b++) r[b] = s[6-b];
    return r;
  endfunction

  function automatic logic [27:0] seg_of(input int d3, input int d2, input int d1, input int d0);
    int d [4];
    logic [27:0] s;
    bit lead;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    s = '1;
    lead = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (BLANK_EN && lead && i > 0 && d[i] == 0) begin
        s[7*i +: 7] = 7'h7F;
      end else begin
        lead = 1'b0;
        s[7*i +: 7] = pat(d[i]);
      end
    end
    return s;
  endfunction

  function automatic logic [27:0] model_seg(input int unsigned v);
    int unsigned sat;
    sat = (v > 9999) ? 9999 : v;
    return seg_of(int'((sat / 1000) % 10), int'((sat / 100) % 10),
                  int'((sat / 10) % 10), int'(sat % 10));
  endfunction

  task automatic run_conv(input logic [13:0] v, input logic [27:0] exp_seg,
                          input logic exp_ovf, input string tag);
    int lat;
    @(negedge clk);
    bus.Load  = 1'b1;
    bus.Value = v;
    @(posedge clk);
    @(negedge clk);
    bus.Load  = 1'b0;
    bus.Value = 14'($urandom);
    chk({tag, "_busy"}, 32'(bus.Busy), 32'd1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.Done) break;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    chk({tag, "_seg"}, 32'(bus.Seg), 32'(exp_seg));
    chk({tag, "_ovf"}, 32'(bus.Overflow), 32'(exp_ovf));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
  endtask

  initial begin
    vec_t        vt [10];
    pend_t       pq [$];
    pend_t       p;
    int unsigned v;
    int          next_free;
    logic        exp_done, exp_busy;

    vt[0] = '{14'd125,   0, 1, 2, 5, 1'b0};
    vt[1] = '{14'd12000, 9, 9, 9, 9, 1'b1};
    vt[2] = '{14'd9999,  9, 9, 9, 9, 1'b0};
    vt[3] = '{14'd0,     0, 0, 0, 0, 1'b0};
    vt[4] = '{14'd16383, 9, 9, 9, 9, 1'b1};
    vt[5] = '{14'd10000, 9, 9, 9, 9, 1'b1};
    vt[6] = '{14'd1000,  1, 0, 0, 0, 1'b0};
    vt[7] = '{14'd9,     0, 0, 0, 9, 1'b0};
    vt[8] = '{14'd8086,  8, 0, 8, 6, 1'b0};
    vt[9] = '{14'd10,    0, 0, 1, 0, 1'b0};

    bus.Load  = 1'b0;
    bus.Value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_seg",  32'(bus.Seg),      32'h0FFF_FFFF);
    chk("reset_busy", 32'(bus.Busy),     32'd0);
    chk("reset_done", 32'(bus.Done),     32'd0);
    chk("reset_ovf",  32'(bus.Overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_conv(vt[i].value, seg_of(vt[i].d3, vt[i].d2, vt[i].d1, vt[i].d0),
               vt[i].ovf, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      v = (i % 3 == 0) ? $urandom_range(9990, 16383) : $urandom_range(0, 16383);
      run_conv(14'(v), model_seg(v), v > 9999, $sformatf("rnd%0d", i));
    end

    // Load held high: only values presented while idle are converted
    next_free = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      v = $urandom_range(0, 16383);
      bus.Load  = 1'b1;
      bus.Value = 14'(v);
      if (k >= next_free) begin
        pq.push_back('{k + int'(LAT), v});
        next_free = k + int'(LAT) + 1;
      end
      @(posedge clk);
      #1;
      exp_done = (pq.size() > 0) && (pq[0].done_edge == k);
      chk($sformatf("cont_done_e%0d", k), 32'(bus.Done), 32'(exp_done));
      if (exp_done) begin
        p = pq.pop_front();
        chk($sformatf("cont_seg_e%0d", k), 32'(bus.Seg), 32'(model_seg(p.val)));
        chk($sformatf("cont_ovf_e%0d", k), 32'(bus.Overflow), 32'(p.val > 9999));
      end
      exp_busy = (pq.size() > 0) && (pq[0].done_edge > k);
      chk($sformatf("cont_busy_e%0d", k), 32'(bus.Busy), 32'(exp_busy));
    end
    @(negedge clk);
    bus.Load = 1'b0;
    repeat (2) @(posedge clk);

    // Reset seven edges into a conversion of 125
    @(negedge clk);
    bus.Load  = 1'b1;
    bus.Value = 14'd125;
    @(posedge clk);
    @(negedge clk);
    bus.Load = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_seg",  32'(bus.Seg),      32'h0FFF_FFFF);
    chk("midrst_busy", 32'(bus.Busy),     32'd0);
    chk("midrst_ovf",  32'(bus.Overflow), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("postrst_done_c%0d", k), 32'(bus.Done), 32'd0);
    end
    chk("postrst_seg",  32'(bus.Seg),  32'h0FFF_FFFF);
    chk("postrst_busy", 32'(bus.Busy), 32'd0);
    run_conv(14'd42, seg_of(0, 0, 4, 2), 1'b0, "after_rst42");

    // Results hold across idle cycles
    run_conv(14'd125, seg_of(0, 1, 2, 5), 1'b0, "hold125");
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_done_c%0d", k), 32'(bus.Done), 32'd0);
      chk($sformatf("hold_seg_c%0d", k), 32'(bus.Seg), 32'(seg_of(0, 1, 2, 5)));
      chk($sformatf("hold_ovf_c%0d", k), 32'(bus.Overflow), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
